score_bcd_conv: RTL and testbench

//  Sequential binary-to-BCD converter downstream of the score counter.

---
 rtl/score_pkg.sv | 15 +
 rtl/bcd_add3.sv | 11 +
 rtl/score_bcd_conv.sv | 144 ++++++++++++++
 tb/tb_score_bcd_conv.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/score_pkg.sv
// Shared types and default sizes for the score binary-to-BCD converter.
package score_pkg;

  localparam int SCORE_W    = 12;
  localparam int BCD_DIGITS = 4;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  typedef logic [3:0] bcd_nibble_t;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble nibble correction: values of 5 and above get +3 before the shift.
module bcd_add3
  import score_pkg::*;
(
  input  bcd_nibble_t nib_in,
  output bcd_nibble_t nib_out
);

  assign nib_out = (nib_in >= 4'd5) ? nib_in + 4'd3 : nib_in;

endmodule

// File: rtl/score_bcd_conv.sv
// Sequential binary-to-BCD converter (shift-add-3, one bit per clock) with 1-deep pending slot.
// Optional best-score tracking is enabled with the HISCORE_EN macro.
//
// state | meaning
// IDLE  | waiting for a strobe or a pending value
// SHIFT | one correction-and-shift per cycle, WIDTH cycles
// DONE  | publish scratch to bcd_out, pulse bcd_valid
module score_bcd_conv
  import score_pkg::*;
#(
  parameter int WIDTH  = SCORE_W,
  parameter int DIGITS = BCD_DIGITS
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  restart,
  input  logic [WIDTH-1:0]      score_in,
  input  logic                  score_valid,
  output logic                  busy,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  bcd_valid,
  output logic [4*DIGITS-1:0]   hiscore_bcd,
  output logic                  new_record
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

  generate
    if (!(10 ** DIGITS > 2 ** WIDTH - 1)) begin : g_size_chk
      $error("score_bcd_conv: DIGITS too small to hold 2**WIDTH-1");
    end
  endgenerate

  state_t               state, state_nxt;
  logic [WIDTH-1:0]     shreg;
  logic [WIDTH-1:0]     pend;
  logic                 pend_full;
  logic [CNT_W-1:0]     cnt;
  logic [BCD_W-1:0]     scratch;
  logic [BCD_W-1:0]     scratch_adj;
  logic                 clr;
  logic                 load;
  logic [WIDTH-1:0]     load_val;

  assign clr      = !resetn || restart;
  assign load     = (state == IDLE) && (score_valid || pend_full);
  assign load_val = score_valid ? score_in : pend;

  for (genvar d = 0; d < DIGITS; d++) begin : g_add3
    bcd_add3 u_add3 (
      .nib_in  (scratch[4*d +: 4]),
      .nib_out (scratch_adj[4*d +: 4])
    );
  end

  always_ff @(posedge clk) begin
    if (clr) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (load) state_nxt = SHIFT;
      SHIFT:   if (cnt == CNT_LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  // A strobe arriving while busy parks in the pending slot; a newer one overwrites it.
  always_ff @(posedge clk) begin
    if (clr) begin
      shreg     <= '0;
      pend      <= '0;
      pend_full <= 1'b0;
      cnt       <= '0;
      scratch   <= '0;
      bcd_out   <= '0;
      bcd_valid <= 1'b0;
    end else begin
      bcd_valid <= 1'b0;
      if (score_valid && state != IDLE) begin
        pend      <= score_in;
        pend_full <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (load) begin
            shreg     <= load_val;
            pend_full <= 1'b0;
            scratch   <= '0;
            cnt       <= CNT_INIT;
          end
        end
        SHIFT: begin
          {scratch, shreg} <= {scratch_adj[BCD_W-2:0], shreg, 1'b0};
          cnt              <= cnt - 1'b1;
        end
        DONE: begin
          bcd_out   <= scratch;
          bcd_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef HISCORE_EN
  logic [WIDTH-1:0] cur_bin;
  logic [WIDTH-1:0] hi_bin;

  // Best score survives restart; only resetn clears it.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cur_bin     <= '0;
      hi_bin      <= '0;
      hiscore_bcd <= '0;
      new_record  <= 1'b0;
    end else begin
      new_record <= 1'b0;
      if (!restart) begin
        if (load) cur_bin <= load_val;
        if (state == DONE && cur_bin > hi_bin) begin
          hi_bin      <= cur_bin;
          hiscore_bcd <= scratch;
          new_record  <= 1'b1;
        end
      end
    end
  end
`else
  assign hiscore_bcd = '0;
  assign new_record  = 1'b0;
`endif

endmodule

// File: tb/tb_score_bcd_conv.sv
// Directed, table-driven bench for score_bcd_conv; follows HISCORE_EN if defined.
module tb_score_bcd_conv;

  logic        clk = 1'b0;
  logic        resetn;
  logic        restart;
  logic [11:0] score_in;
  logic        score_valid;
  logic        busy;
  logic [15:0] bcd_out;
  logic        bcd_valid;
  logic [15:0] hiscore_bcd;
  logic        new_record;

  int n_tests = 0;
  int n_fail  = 0;

  logic [11:0] tb_hi;
  logic [15:0] tb_hi_bcd;

  typedef struct {
    logic [11:0] score;
    logic [15:0] bcd;
  } vec_t;

  vec_t vecs[10];

  score_bcd_conv dut (
    .clk         (clk),
    .resetn      (resetn),
    .restart     (restart),
    .score_in    (score_in),
    .score_valid (score_valid),
    .busy        (busy),
    .bcd_out     (bcd_out),
    .bcd_valid   (bcd_valid),
    .hiscore_bcd (hiscore_bcd),
    .new_record  (new_record)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_conv(input logic [11:0] s, input logic [15:0] exp_bcd, input string nm);
    int   n;
    int   nbusy;
    bit   seen;
    logic exp_nr;
    @(negedge clk);
    score_in    = s;
    score_valid = 1'b1;
    n = 0; nbusy = 0; seen = 1'b0;
    while (!seen && n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (n == 1) begin
        score_valid = 1'b0;
        score_in    = ~s;
      end
      if (busy) nbusy++;
      if (bcd_valid) seen = 1'b1;
    end
    check({nm, " valid_seen"}, 32'(seen), 32'd1);
    check({nm, " latency"}, n, 14);
    check({nm, " busy_cycles"}, nbusy, 13);
    check({nm, " bcd_out"}, 32'(bcd_out), 32'(exp_bcd));
    exp_nr = 1'b0;
`ifdef HISCORE_EN
    if (s > tb_hi) begin
      exp_nr    = 1'b1;
      tb_hi     = s;
      tb_hi_bcd = exp_bcd;
    end
`endif
    check({nm, " new_record"}, 32'(new_record), 32'(exp_nr));
    check({nm, " hiscore_bcd"}, 32'(hiscore_bcd), 32'(tb_hi_bcd));
    @(negedge clk);
    check({nm, " valid_single"}, 32'(bcd_valid), 32'd0);
    check({nm, " new_record_single"}, 32'(new_record), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset bcd_out", 32'(bcd_out), 32'd0);
    check("reset bcd_valid", 32'(bcd_valid), 32'd0);
    check("reset hiscore_bcd", 32'(hiscore_bcd), 32'd0);
    check("reset new_record", 32'(new_record), 32'd0);
    resetn    = 1'b1;
    tb_hi     = '0;
    tb_hi_bcd = '0;
  endtask

  task automatic strobe(input logic [11:0] s);
    @(negedge clk);
    score_in    = s;
    score_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    score_valid = 1'b0;
    score_in    = 12'hABC;
  endtask

  initial begin
    int npulse;
    int t;
    int t_first;
    int t_second;
    logic [15:0] v_first;
    logic [15:0] v_second;

    vecs[0] = '{12'd4095, 16'h4095};
    vecs[1] = '{12'd0,    16'h0000};
    vecs[2] = '{12'd9,    16'h0009};
    vecs[3] = '{12'd10,   16'h0010};
    vecs[4] = '{12'd99,   16'h0099};
    vecs[5] = '{12'd100,  16'h0100};
    vecs[6] = '{12'd999,  16'h0999};
    vecs[7] = '{12'd1000, 16'h1000};
    vecs[8] = '{12'd1234, 16'h1234};
    vecs[9] = '{12'd2048, 16'h2048};

    resetn      = 1'b0;
    restart     = 1'b0;
    score_in    = '0;
    score_valid = 1'b0;
    tb_hi       = '0;
    tb_hi_bcd   = '0;
    repeat (2) @(posedge clk);
    do_reset();

    for (int i = 0; i < 10; i++)
      run_conv(vecs[i].score, vecs[i].bcd, $sformatf("vec%0d", i));

    // Two strobes while busy: 8 is overwritten by 9, which converts right after 7.
    @(negedge clk);
    score_in = 12'd7; score_valid = 1'b1;
    npulse = 0; t_first = 0; t_second = 0; v_first = '0; v_second = '0;
    for (t = 1; t <= 50; t++) begin
      @(posedge clk);
      @(negedge clk);
      score_valid = 1'b0;
      if (t == 3) begin score_in = 12'd8; score_valid = 1'b1; end
      if (t == 6) begin score_in = 12'd9; score_valid = 1'b1; end
      if (bcd_valid) begin
        npulse++;
        if (npulse == 1) begin t_first = t; v_first = bcd_out; end
        if (npulse == 2) begin t_second = t; v_second = bcd_out; end
      end
    end
    check("pend pulses", npulse, 2);
    check("pend first value", 32'(v_first), 32'h0007);
    check("pend second value", 32'(v_second), 32'h0009);
    check("pend first latency", t_first, 14);
    check("pend second latency", t_second, 28);

    // restart in mid-SHIFT aborts the conversion but keeps the best score.
    @(negedge clk);
    score_in = 12'd1234; score_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    score_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("restart pre busy", 32'(busy), 32'd1);
    restart = 1'b1;
    @(posedge clk);
    @(negedge clk);
    restart = 1'b0;
    check("restart busy", 32'(busy), 32'd0);
    check("restart bcd_out", 32'(bcd_out), 32'd0);
    check("restart bcd_valid", 32'(bcd_valid), 32'd0);
    check("restart hiscore kept", 32'(hiscore_bcd), 32'(tb_hi_bcd));
    npulse = 0;
    repeat (20) begin
      @(negedge clk);
      if (bcd_valid) npulse++;
    end
    check("restart no pulse", npulse, 0);
    run_conv(12'd56, 16'h0056, "after_restart");

    // resetn during SHIFT with a pending value: nothing comes out afterwards.
    strobe(12'd77);
    repeat (2) @(posedge clk);
    strobe(12'd88);
    do_reset();
    npulse = 0;
    repeat (40) begin
      @(negedge clk);
      if (bcd_valid || busy) npulse++;
    end
    check("reset no activity", npulse, 0);

    run_conv(12'd100, 16'h0100, "hi100");
    run_conv(12'd50,  16'h0050, "hi50");
    run_conv(12'd100, 16'h0100, "hi100b");
    run_conv(12'd101, 16'h0101, "hi101");
    @(negedge clk);
    restart = 1'b1;
    @(posedge clk);
    @(negedge clk);
    restart = 1'b0;
`ifdef HISCORE_EN
    check("hiscore after restart", 32'(hiscore_bcd), 32'h0101);
`else
    check("hiscore after restart", 32'(hiscore_bcd), 32'h0000);
`endif
    check("bcd_out after restart", 32'(bcd_out), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
